fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined MIPS core: owns the PC register, drives the instruction-memory request/acknowledge handshake, and loads the IF/ID pipeline register (`InstrD`, `PC4D`). It consumes the next-PC value `NPC` and the decode-stage `redirect` flag produced downstream from `PC4D`. It honours the single MIPS branch delay slot: the instruction being fetched when a branch or jump leaves decode is kept, and the fetch after it goes to `NPC`.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value after reset.
- `NOP`, default 32'h0000_0000: instruction word loaded into `InstrD` for a bubble.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset (0 = reset).
- `NPC`  in  32  next-PC target from the decode-stage next-PC logic; bits [1:0] ignored.
- `redirect`  in  1  decode instruction is a branch/jump whose target is `NPC`; meaningful only while `validD`=1.
- `stallD`  in  1  hazard stall: decode holds, IF/ID must not change.
- `imem_req`  out  1  instruction-memory request.
- `imem_addr`  out  32  fetch address, always word-aligned.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word.
- `InstrD`  out  32  IF/ID instruction.
- `PC4D`  out  32  IF/ID fetch address + 4.
- `validD`  out  1  IF/ID holds a real instruction (0 = bubble).

## Operation
- Registers: `PC`, `state` {FETCH, HOLD}, `buf` (32b skid buffer), `pend_v`/`pend_tgt` (latched redirect), IF/ID (`InstrD`, `PC4D`, `validD`).
- `imem_req` = (state==FETCH) & `reset`; `imem_addr` = {PC[31:2],2'b00}. Address held stable until ack.
- `take` = `validD` & `redirect` & !`stallD` (branch leaves decode this cycle).
- `nxt` = `pend_v` ? `pend_tgt` : (`take` ? {NPC[31:2],2'b00} : PC+4). PC+4 wraps modulo 2^32.
- FETCH, `imem_ack` & !`stallD`: IF/ID <= {`imem_rdata`, PC+4, 1}; PC <= `nxt`; clear `pend_v`; stay in FETCH.
- FETCH, `imem_ack` & `stallD`: `buf` <= `imem_rdata`; go to HOLD; PC, IF/ID unchanged.
- FETCH, no ack, !`stallD`: IF/ID <= {NOP, PC4D unchanged, 0} (bubble). If `take`, `pend_v` <= 1 and `pend_tgt` <= NPC.
- FETCH, no ack, `stallD`: nothing changes.
- HOLD: `imem_req`=0. When !`stallD`: IF/ID <= {`buf`, PC+4, 1}; PC <= `nxt`; clear `pend_v`; go to FETCH.
- `take` and a completing fetch in the same cycle: the fetched word is the delay slot, and PC <= NPC.
- `take` can occur in HOLD only if `stallD` drops, which is also the completing cycle, so the same rule applies.
- Reset (`reset`=0, edge-sampled): PC=RESET_PC, state=FETCH, `validD`=0, `InstrD`=NOP, `PC4D`=0, `pend_v`=0, `buf`=0. Any in-flight request is abandoned, and an ack in the reset cycle is ignored. `imem_req`=0 during the reset cycle.

## Timing
- A zero-wait memory (ack in the request cycle) gives one instruction per cycle. `InstrD` is valid the cycle after the ack.
- N wait cycles insert N bubbles (`validD`=0) into decode.
- A stall during an ack costs no memory re-access: the word is replayed from `buf`.
- A redirect takes effect on the first fetch issued after the delay slot completes, with no lost or duplicated fetch.
- Request rule: once `imem_req`=1, `imem_addr` is constant until the ack cycle.

## Structure
- Shared package: `RESET_PC` and `NOP` defaults and the `state` encoding (FETCH=1'b0, HOLD=1'b1), reused by the hazard unit and the bench.
- One natural sub-module: `if_id_reg` (IF/ID register with load/bubble/hold controls, synchronous active-low reset). The PC, FSM, skid buffer and pending-redirect logic stay in `fetch_stage`.

## Test plan
- Reset, then zero-wait memory returning `PC` as data for 4 cycles:
  - addresses are 0x3000, 0x3004, 0x3008, 0x300C;
  - `PC4D` is 0x3004…0x3010, one per cycle;
  - `validD`=0 in the first cycle after reset.
- Ack at 0x3008 with `stallD`=1 for 3 cycles:
  - `imem_req` drops;
  - `InstrD` holds the previous word;
  - when `stallD` falls, `InstrD` = the word from 0x3008 and `PC4D`=0x300C, and the next request is 0x300C.
- Branch in decode (`redirect`=1, NPC=0x3100) while 0x3008 is acked the same cycle:
  - 0x3008 enters decode (delay slot);
  - the next address is 0x3100.
- Same branch, but memory acks 0x3008 two cycles late:
  - two bubbles, `pend_v`=1;
  - 0x3008 is still delivered;
  - the next address is 0x3100, not 0x300C.
- Reset asserted while a request is waiting for ack, with ack arriving in the reset cycle:
  - the ack is ignored;
  - the next request is 0x3000 and `validD`=0.
- PC=0xFFFF_FFFC fetched:
  - `PC4D`=0x0000_0000;
  - the next address is 0x0000_0000.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: reset defaults and the fetch FSM encoding,
// reused by the hazard unit and the testbench.
package fetch_stage_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
   localparam logic [31:0] DEFAULT_NOP      = 32'h0000_0000;
   localparam logic [31:0] WORD_MASK        = 32'hFFFF_FFFC;

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched word, insert a bubble, or hold.
// Reset (synchronous, active-low) leaves a bubble carrying the NOP word.
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] NOP = DEFAULT_NOP
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_load,
   input  logic        i_bubble,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc4,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc4,
   output logic        o_valid
);

   logic [31:0] r_instr;
   logic [31:0] r_pc4;
   logic        r_valid;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from the same pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_instr <= NOP;
         r_pc4   <= 32'h0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_instr <= i_instr;
         r_pc4   <= i_pc4;
         r_valid <= 1'b1;
      end else if (i_bubble) begin
         // PC4D is left alone so a bubble never disturbs the next-PC logic.
         r_instr <= NOP;
         r_valid <= 1'b0;
      end
   end

   assign o_instr = r_instr;
   assign o_pc4   = r_pc4;
   assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, imem handshake, skid buffer for stalls
// during an ack, and a latched redirect so the branch delay slot is honoured.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter logic [31:0] NOP      = DEFAULT_NOP
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] NPC,
   input  logic        redirect,
   input  logic        stallD,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] InstrD,
   output logic [31:0] PC4D,
   output logic        validD
);

   fetch_state_e r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_buf;
   logic         r_pend_v;
   logic [31:0]  r_pend_tgt;

   logic         w_take;
   logic         w_complete;
   logic         w_bubble;
   logic [31:0]  w_pc4;
   logic [31:0]  w_nxt;
   logic [31:0]  w_instr;

   assign w_pc4      = r_pc + 32'd4;
   assign w_take     = validD & redirect & ~stallD;
   assign w_nxt      = (r_pend_v ? r_pend_tgt : (w_take ? NPC : w_pc4)) & WORD_MASK;
   assign w_complete = ~stallD & ((r_state == HOLD) | imem_ack);
   assign w_bubble   = (r_state == FETCH) & ~imem_ack & ~stallD;
   assign w_instr    = (r_state == HOLD) ? r_buf : imem_rdata;

   assign imem_req  = (r_state == FETCH) & reset;
   assign imem_addr = r_pc & WORD_MASK;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state  <= FETCH;
         r_pc     <= RESET_PC & WORD_MASK;
         r_buf    <= 32'h0;
         r_pend_v <= 1'b0;
      end else begin
         case (r_state)
            FETCH: begin
               if (imem_ack) begin
                  if (!stallD) begin
                     r_pc     <= w_nxt;
                     r_pend_v <= 1'b0;
                  end else begin
                     r_buf   <= imem_rdata;
                     r_state <= HOLD;
                  end
               end else if (w_take) begin
                  // Delay slot still in flight: remember where to go after it.
                  r_pend_v   <= 1'b1;
                  r_pend_tgt <= NPC;
               end
            end
            HOLD: begin
               if (!stallD) begin
                  r_pc     <= w_nxt;
                  r_pend_v <= 1'b0;
                  r_state  <= FETCH;
               end
            end
            default: r_state <= FETCH;
         endcase
      end
   end

   // NOTE: r_pend_tgt carries no reset; it is only ever read while r_pend_v
   // is set, and r_pend_v itself is reset.

   if_id_reg #(
      .NOP (NOP)
   ) u_if_id (
      .clk      (clk),
      .reset    (reset),
      .i_load   (w_complete),
      .i_bubble (w_bubble),
      .i_instr  (w_instr),
      .i_pc4    (w_pc4),
      .o_instr  (InstrD),
      .o_pc4    (PC4D),
      .o_valid  (validD)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: streaming, stall replay, delay slot,
// late ack with pending redirect, reset abandon and PC wrap.
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   logic        clk;
   logic        reset;
   logic [31:0] NPC;
   logic        redirect;
   logic        stallD;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] InstrD;
   logic [31:0] PC4D;
   logic        validD;

   int n_checks;
   int n_errors;

   fetch_stage dut (
      .clk        (clk),
      .reset      (reset),
      .NPC        (NPC),
      .redirect   (redirect),
      .stallD     (stallD),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .InstrD     (InstrD),
      .PC4D       (PC4D),
      .validD     (validD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic rst, input logic ack, input logic [31:0] rdata,
                        input logic stall, input logic redir, input logic [31:0] npc);
      @(negedge clk);
      reset      = rst;
      imem_ack   = ack;
      imem_rdata = rdata;
      stallD     = stall;
      redirect   = redir;
      NPC        = npc;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1'b0, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
      tick();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
   endtask

   // Zero-wait fetch of addr, memory returns the address as data.
   task automatic fetch_ok(input logic [31:0] addr, input logic redir, input logic [31:0] npc);
      drive(1'b1, 1'b1, addr, 1'b0, redir, npc);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== addr) begin
         n_errors++;
         $display("FAIL fetch_addr: req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, addr);
      end
      tick();
      n_checks++;
      if (InstrD !== addr || PC4D !== addr + 32'd4 || validD !== 1'b1) begin
         n_errors++;
         $display("FAIL fetch_ifid: InstrD=%h PC4D=%h validD=%b, expected %h %h 1",
                  InstrD, PC4D, validD, addr, addr + 32'd4);
      end
   endtask

   task automatic test_reset();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (imem_req !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_req: imem_req=%b, expected 0", imem_req);
      end
      tick();
      n_checks++;
      if (validD !== 1'b0 || InstrD !== DEFAULT_NOP || PC4D !== 32'h0) begin
         n_errors++;
         $display("FAIL reset_ifid: validD=%b InstrD=%h PC4D=%h, expected 0 %h 0", validD, InstrD, PC4D, DEFAULT_NOP);
      end
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin
         n_errors++;
         $display("FAIL reset_first_req: req=%b addr=%h, expected 1 00003000", imem_req, imem_addr);
      end
      tick();
      n_checks++;
      if (validD !== 1'b0 || imem_addr !== 32'h0000_3000) begin
         n_errors++;
         $display("FAIL reset_wait_bubble: validD=%b addr=%h, expected 0 00003000", validD, imem_addr);
      end
   endtask

   task automatic test_stream();
      do_reset();
      drive(1'b1, 1'b1, 32'h0000_3000, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (validD !== 1'b0) begin
         n_errors++;
         $display("FAIL stream_first_valid: validD=%b, expected 0", validD);
      end
      tick();
      n_checks++;
      if (InstrD !== 32'h0000_3000 || PC4D !== 32'h0000_3004 || validD !== 1'b1) begin
         n_errors++;
         $display("FAIL stream_first: InstrD=%h PC4D=%h validD=%b, expected 00003000 00003004 1", InstrD, PC4D, validD);
      end
      for (int k = 1; k < 4; k++) fetch_ok(32'h0000_3000 + 32'(4 * k), 1'b0, 32'h0);
   endtask

   task automatic test_stall_replay();
      do_reset();
      fetch_ok(32'h0000_3000, 1'b0, 32'h0);
      fetch_ok(32'h0000_3004, 1'b0, 32'h0);
      drive(1'b1, 1'b1, 32'h0000_3008, 1'b1, 1'b0, 32'h0);
      tick();
      n_checks++;
      if (imem_req !== 1'b0 || InstrD !== 32'h0000_3004 || PC4D !== 32'h0000_3008) begin
         n_errors++;
         $display("FAIL stall_enter: req=%b InstrD=%h PC4D=%h, expected 0 00003004 00003008", imem_req, InstrD, PC4D);
      end
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
         tick();
         n_checks++;
         if (imem_req !== 1'b0 || InstrD !== 32'h0000_3004 || validD !== 1'b1) begin
            n_errors++;
            $display("FAIL stall_hold: req=%b InstrD=%h validD=%b, expected 0 00003004 1", imem_req, InstrD, validD);
         end
      end
      drive(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
      tick();
      n_checks++;
      if (InstrD !== 32'h0000_3008 || PC4D !== 32'h0000_300C || validD !== 1'b1) begin
         n_errors++;
         $display("FAIL stall_replay: InstrD=%h PC4D=%h validD=%b, expected 00003008 0000300c 1", InstrD, PC4D, validD);
      end
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0000_300C) begin
         n_errors++;
         $display("FAIL stall_next_req: req=%b addr=%h, expected 1 0000300c", imem_req, imem_addr);
      end
   endtask

   task automatic test_branch_delay_slot();
      do_reset();
      fetch_ok(32'h0000_3000, 1'b0, 32'h0);
      fetch_ok(32'h0000_3004, 1'b0, 32'h0);
      // 0x3004 in decode is the branch; low NPC bits must be dropped.
      fetch_ok(32'h0000_3008, 1'b1, 32'h0000_3103);
      n_checks++;
      if (imem_addr !== 32'h0000_3100) begin
         n_errors++;
         $display("FAIL branch_target: addr=%h, expected 00003100", imem_addr);
      end
      fetch_ok(32'h0000_3100, 1'b0, 32'h0);
   endtask

   task automatic test_late_ack_branch();
      do_reset();
      fetch_ok(32'h0000_3000, 1'b0, 32'h0);
      fetch_ok(32'h0000_3004, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_3100);
      tick();
      n_checks++;
      if (validD !== 1'b0 || InstrD !== DEFAULT_NOP || PC4D !== 32'h0000_3008 || imem_addr !== 32'h0000_3008) begin
         n_errors++;
         $display("FAIL late_bubble1: validD=%b InstrD=%h PC4D=%h addr=%h, expected 0 %h 00003008 00003008",
                  validD, InstrD, PC4D, imem_addr, DEFAULT_NOP);
      end
      // Redirect with validD=0 must be ignored; the latched target wins.
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_3200);
      tick();
      n_checks++;
      if (validD !== 1'b0 || imem_addr !== 32'h0000_3008) begin
         n_errors++;
         $display("FAIL late_bubble2: validD=%b addr=%h, expected 0 00003008", validD, imem_addr);
      end
      fetch_ok(32'h0000_3008, 1'b0, 32'h0);
      n_checks++;
      if (imem_addr !== 32'h0000_3100) begin
         n_errors++;
         $display("FAIL late_target: addr=%h, expected 00003100", imem_addr);
      end
   endtask

   task automatic test_reset_abandon();
      do_reset();
      fetch_ok(32'h0000_3000, 1'b0, 32'h0);
      fetch_ok(32'h0000_3004, 1'b0, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      tick();
      drive(1'b0, 1'b1, 32'h0000_3008, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (imem_req !== 1'b0) begin
         n_errors++;
         $display("FAIL abandon_req: imem_req=%b, expected 0", imem_req);
      end
      tick();
      n_checks++;
      if (validD !== 1'b0 || InstrD !== DEFAULT_NOP || PC4D !== 32'h0) begin
         n_errors++;
         $display("FAIL abandon_ifid: validD=%b InstrD=%h PC4D=%h, expected 0 %h 0", validD, InstrD, PC4D, DEFAULT_NOP);
      end
      drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000 || validD !== 1'b0) begin
         n_errors++;
         $display("FAIL abandon_restart: req=%b addr=%h validD=%b, expected 1 00003000 0", imem_req, imem_addr, validD);
      end
      tick();
   endtask

   task automatic test_pc_wrap();
      do_reset();
      fetch_ok(32'h0000_3000, 1'b0, 32'h0);
      fetch_ok(32'h0000_3004, 1'b1, 32'hFFFF_FFFC);
      fetch_ok(32'hFFFF_FFFC, 1'b0, 32'h0);
      n_checks++;
      if (PC4D !== 32'h0000_0000 || imem_addr !== 32'h0000_0000) begin
         n_errors++;
         $display("FAIL pc_wrap: PC4D=%h addr=%h, expected 00000000 00000000", PC4D, imem_addr);
      end
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      reset      = 1'b0;
      NPC        = 32'h0;
      redirect   = 1'b0;
      stallD     = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;

      test_reset();
      test_stream();
      test_stall_replay();
      test_branch_delay_slot();
      test_late_ack_branch();
      test_reset_abandon();
      test_pc_wrap();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
